mips_exec_ctrl: RTL and testbench
=================================

// Module: mips_exec_ctrl
// PURPOSE
//  Multi-cycle MIPS control/execute core: sequencing FSM, combinational control decode and ALU with HI/LO.
//  Sits between IR/regfile/PC and the Avalon bus; the CPU top supplies decoded fields, register data and
//  bus readdata (already big-endian). It returns control enables, ALU results and the bus address select.
// PARAMETERS
//  none (widths fixed: 32-bit data, 5-bit register address)
// PORTS
//  clk               in   1   clock; all state updates on posedge
//  reset             in   1   synchronous, active-high reset
//  halt_i            in   1   PC==0 indication from top
//  waitrequest_i     in   1   Avalon waitrequest
//  opcode_i          in   6   instruction opcode (opcode_t)
//  funct_i           in   6   instruction funct (func_t)
//  rs_i, rt_i        in   32  register file read data for rs / rt
//  immediate_i       in   16  instruction immediate
//  ram_readdata_i    in   32  bus readdata, big-endian ordered
//  state_o           out  2   FSM state (state_t)
//  active_o          out  1   state_o != HALT
//  pc_write_en_o, ir_write_en_o, regfile_write_en_o             out 1 each
//  ram_read_en_o, ram_write_en_o, ram_addr_sel_o (1=EA, 0=PC)     out 1 each
//  ram_byte_en_o     out  4   byteenable
//  src_b_sel_o       out  1   1 = sign-extended immediate is ALU operand B
//  regfile_addr_3_sel_o out 1 REGFILE_ADDR_SEL_RD(0) / REGFILE_ADDR_SEL_RT(1)
//  rd_o, rt_o        out  32  result for rd-destination / rt-destination (rt_o = store data for SW)
//  effective_address_o out 32 rs_i + sign_ext(immediate_i)
//  mfhi_o, mflo_o    out  32  HI / LO register contents
// BEHAVIOUR
//  stall = (ram_read_en_o | ram_write_en_o) & waitrequest_i; stall holds FSM state and suppresses all *_en writes.
//  States: FETCH -> EXEC -> FETCH; HALT sticky until reset. Reset (any state, mid-stall too) -> FETCH, HI=LO=0.
//  FETCH: if halt_i -> HALT (no bus access). Else read=1, addr_sel=0, ir_write_en=!stall; leave when !stall.
//  EXEC: pc_write_en=!stall for every opcode. LW: read=1, addr_sel=1, regfile_write_en=!stall, dest rt,
//   rt_o=ram_readdata_i. SW: write=1, addr_sel=1, rt_o=rt_i. ALU ops: regfile_write_en=1, no bus.
//  HALT: all enables 0, active_o=0. byteenable=4'b1111 whenever read/write, else 4'b0000.
//  R-type (dest rd): ADDU SUBU AND OR XOR NOR SLT SLTU SLLV SRLV SRAV (shift amount rs_i[4:0]), MFHI MFLO; JR writes no reg.
//  I-type (dest rt, src_b_sel=1): ADDIU SLTI SLTIU (sign-ext imm), ANDI ORI XORI (zero-ext), LUI {imm,16'h0}.
//  Arithmetic mod 2^32, no overflow traps. SLT signed, SLTU/SLTIU unsigned compare of sign-extended imm.
//  Unsupported opcode/funct: NOP (PC advances, no reg/bus write).
// CONFIGURATION
//  MIPS_MULTDIV_EN defined: MULT MULTU DIV DIVU MTHI MTLO update HI/LO at posedge of unstalled EXEC; MULT{U}
//   {HI,LO}=64-bit product; DIV{U} LO=quotient, HI=remainder (signed: truncate toward zero); divisor 0 leaves HI/LO unchanged.
//  Undefined: those functs are NOPs; HI/LO hold reset value 0, so MFHI/MFLO return 0.
// STRUCTURE
//  Package codes: size_t, regaddr_t, state_t {FETCH,EXEC,HALT}, opcode_t, func_t, regimm_t, REGFILE_ADDR_SEL_* constants.
//  One sub-module: exec_alu (datapath + HI/LO); FSM and control decode inline.
// TESTING
//  Reset, then FETCH with waitrequest=1 for 3 cycles -> state stays FETCH, ir_write_en=0; drop -> EXEC next cycle.
//  ADDIU rs=32'h0000_0005 imm=16'hFFFF -> rt_o=32'h4, regfile_addr_3_sel=RT, regfile_write_en=1.
//  LW rs=32'h1000 imm=16'h0004 -> address_sel=1, effective_address=32'h1004, rt_o=ram_readdata_i.
//  halt_i=1 in FETCH -> HALT, active_o=0, read=write=0 until reset.
//  MIPS_MULTDIV_EN: MULT 32'hFFFF_FFFE*3 -> HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA; DIVU 7/0 -> HI/LO unchanged.
//  SLT rs=32'h8000_0000 rt=1 -> rd_o=1; SLTU same operands -> rd_o=0.

Source files
------------

// File: rtl/mips_exec_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control/execute core.
// Holds FSM state, opcode/funct/regimm encodings, register-file address-select
// constants and a sign-extension helper used by the datapath.
package mips_exec_ctrl_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned IMM_W      = 16;

    typedef logic [DATA_W-1:0]     size_t;
    typedef logic [REG_ADDR_W-1:0] regaddr_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    typedef enum logic [5:0] {
        OP_SPECIAL = 6'h00,
        OP_REGIMM  = 6'h01,
        OP_ADDIU   = 6'h09,
        OP_SLTI    = 6'h0A,
        OP_SLTIU   = 6'h0B,
        OP_ANDI    = 6'h0C,
        OP_ORI     = 6'h0D,
        OP_XORI    = 6'h0E,
        OP_LUI     = 6'h0F,
        OP_LW      = 6'h23,
        OP_SW      = 6'h2B
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLLV  = 6'h04,
        FN_SRLV  = 6'h06,
        FN_SRAV  = 6'h07,
        FN_JR    = 6'h08,
        FN_MFHI  = 6'h10,
        FN_MTHI  = 6'h11,
        FN_MFLO  = 6'h12,
        FN_MTLO  = 6'h13,
        FN_MULT  = 6'h18,
        FN_MULTU = 6'h19,
        FN_DIV   = 6'h1A,
        FN_DIVU  = 6'h1B,
        FN_ADDU  = 6'h21,
        FN_SUBU  = 6'h23,
        FN_AND   = 6'h24,
        FN_OR    = 6'h25,
        FN_XOR   = 6'h26,
        FN_NOR   = 6'h27,
        FN_SLT   = 6'h2A,
        FN_SLTU  = 6'h2B
    } func_t;

    typedef enum logic [4:0] {
        RI_BLTZ   = 5'h00,
        RI_BGEZ   = 5'h01,
        RI_BLTZAL = 5'h10,
        RI_BGEZAL = 5'h11
    } regimm_t;

    localparam logic REGFILE_ADDR_SEL_RD = 1'b0;
    localparam logic REGFILE_ADDR_SEL_RT = 1'b1;

    function automatic size_t sign_ext(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/mips_exec_ctrl_alu.sv
// exec_alu: combinational ALU for R-type and I-type results plus the HI/LO pair.
// Ports: clk/reset (sync, active-high), hilo_en_i (unstalled EXEC), opcode_i,
//        funct_i, rs_i, rt_i, immediate_i, ram_readdata_i in;
//        rd_o (rd-destination result), rt_o (rt-destination result / SW data),
//        effective_address_o, mfhi_o, mflo_o out.
// Build option: MIPS_MULTDIV_EN enables MULT/MULTU/DIV/DIVU/MTHI/MTLO; without it
//        HI/LO stay at their reset value of zero.
import mips_exec_ctrl_pkg::*;

module exec_alu (
    input  logic        clk,
    input  logic        reset,
    input  logic        hilo_en_i,
    input  logic [5:0]  opcode_i,
    input  logic [5:0]  funct_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic [15:0] immediate_i,
    input  logic [31:0] ram_readdata_i,
    output logic [31:0] rd_o,
    output logic [31:0] rt_o,
    output logic [31:0] effective_address_o,
    output logic [31:0] mfhi_o,
    output logic [31:0] mflo_o
);

    size_t hi_q, hi_d;
    size_t lo_q, lo_d;
    size_t imm_sext, imm_zext;

    assign imm_sext            = sign_ext(immediate_i);
    assign imm_zext            = {16'h0000, immediate_i};
    assign effective_address_o = rs_i + imm_sext;
    assign mfhi_o              = hi_q;
    assign mflo_o              = lo_q;

    // R-type result; shift amount comes from rs_i[4:0]
    always_comb begin
        rd_o = '0;
        case (funct_i)
            FN_ADDU: rd_o = rs_i + rt_i;
            FN_SUBU: rd_o = rs_i - rt_i;
            FN_AND:  rd_o = rs_i & rt_i;
            FN_OR:   rd_o = rs_i | rt_i;
            FN_XOR:  rd_o = rs_i ^ rt_i;
            FN_NOR:  rd_o = ~(rs_i | rt_i);
            FN_SLT:  rd_o = 32'($signed(rs_i) < $signed(rt_i));
            FN_SLTU: rd_o = 32'(rs_i < rt_i);
            FN_SLLV: rd_o = rt_i << rs_i[4:0];
            FN_SRLV: rd_o = rt_i >> rs_i[4:0];
            FN_SRAV: rd_o = $unsigned($signed(rt_i) >>> rs_i[4:0]);
            FN_MFHI: rd_o = hi_q;
            FN_MFLO: rd_o = lo_q;
            default: rd_o = '0;
        endcase
    end

    // I-type result, load data, or store data
    always_comb begin
        rt_o = '0;
        case (opcode_i)
            OP_ADDIU: rt_o = rs_i + imm_sext;
            OP_SLTI:  rt_o = 32'($signed(rs_i) < $signed(imm_sext));
            OP_SLTIU: rt_o = 32'(rs_i < imm_sext);
            OP_ANDI:  rt_o = rs_i & imm_zext;
            OP_ORI:   rt_o = rs_i | imm_zext;
            OP_XORI:  rt_o = rs_i ^ imm_zext;
            OP_LUI:   rt_o = {immediate_i, 16'h0000};
            OP_LW:    rt_o = ram_readdata_i;
            OP_SW:    rt_o = rt_i;
            default:  rt_o = '0;
        endcase
    end

`ifdef MIPS_MULTDIV_EN
    logic [63:0] prod;

    // HI/LO next value; a zero divisor leaves both untouched
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        prod = '0;
        if (hilo_en_i && (opcode_i == OP_SPECIAL)) begin
            case (funct_i)
                FN_MULT: begin
                    prod = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end
                FN_MULTU: begin
                    prod = {32'h0, rs_i} * {32'h0, rt_i};
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end
                FN_DIV: begin
                    if (rt_i != '0) begin
                        lo_d = $unsigned($signed(rs_i) / $signed(rt_i));
                        hi_d = $unsigned($signed(rs_i) % $signed(rt_i));
                    end
                end
                FN_DIVU: begin
                    if (rt_i != '0) begin
                        lo_d = rs_i / rt_i;
                        hi_d = rs_i % rt_i;
                    end
                end
                FN_MTHI: hi_d = rs_i;
                FN_MTLO: lo_d = rs_i;
                default: ;
            endcase
        end
    end
`else
    logic unused_hilo_en;
    assign unused_hilo_en = hilo_en_i;

    // No multiply/divide unit: HI/LO keep their reset value
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
    end
`endif

    // HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

endmodule

// File: rtl/mips_exec_ctrl.sv
// mips_exec_ctrl: multi-cycle MIPS sequencing FSM (FETCH -> EXEC -> FETCH, sticky
// HALT), control decode and the exec_alu datapath.
// Ports: clk, reset (sync, active-high), halt_i, waitrequest_i, opcode_i, funct_i,
//        rs_i, rt_i, immediate_i, ram_readdata_i in; state_o, active_o, write/read
//        enables, ram_addr_sel_o (1=EA, 0=PC), ram_byte_en_o, src_b_sel_o,
//        regfile_addr_3_sel_o, rd_o, rt_o, effective_address_o, mfhi_o, mflo_o out.
// Build option: MIPS_MULTDIV_EN (see exec_alu).
import mips_exec_ctrl_pkg::*;

module mips_exec_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        halt_i,
    input  logic        waitrequest_i,
    input  logic [5:0]  opcode_i,
    input  logic [5:0]  funct_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic [15:0] immediate_i,
    input  logic [31:0] ram_readdata_i,
    output logic [1:0]  state_o,
    output logic        active_o,
    output logic        pc_write_en_o,
    output logic        ir_write_en_o,
    output logic        regfile_write_en_o,
    output logic        ram_read_en_o,
    output logic        ram_write_en_o,
    output logic        ram_addr_sel_o,
    output logic [3:0]  ram_byte_en_o,
    output logic        src_b_sel_o,
    output logic        regfile_addr_3_sel_o,
    output logic [31:0] rd_o,
    output logic [31:0] rt_o,
    output logic [31:0] effective_address_o,
    output logic [31:0] mfhi_o,
    output logic [31:0] mflo_o
);

    state_t state_q, state_d;
    logic   is_lw_c, is_sw_c, is_ialu_c, is_ralu_c;
    logic   bus_rd_c, bus_wr_c, stall_c;

    // Instruction class decode
    assign is_lw_c   = (opcode_i == OP_LW);
    assign is_sw_c   = (opcode_i == OP_SW);
    assign is_ialu_c = opcode_i inside {OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI,
                                        OP_ORI, OP_XORI, OP_LUI};
    assign is_ralu_c = (opcode_i == OP_SPECIAL) &&
                       (funct_i inside {FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR,
                                        FN_NOR, FN_SLT, FN_SLTU, FN_SLLV, FN_SRLV,
                                        FN_SRAV, FN_MFHI, FN_MFLO});

    // Bus requests are derived from state directly so stall has no loop through outputs
    assign bus_rd_c = ((state_q == FETCH) && !halt_i) || ((state_q == EXEC) && is_lw_c);
    assign bus_wr_c = (state_q == EXEC) && is_sw_c;
    assign stall_c  = (bus_rd_c || bus_wr_c) && waitrequest_i;

    assign ram_read_en_o  = bus_rd_c;
    assign ram_write_en_o = bus_wr_c;
    assign ram_byte_en_o  = (bus_rd_c || bus_wr_c) ? 4'b1111 : 4'b0000;
    assign state_o        = state_q;
    assign active_o       = (state_q != HALT);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and control enables
    always_comb begin
        state_d              = state_q;
        pc_write_en_o        = 1'b0;
        ir_write_en_o        = 1'b0;
        regfile_write_en_o   = 1'b0;
        ram_addr_sel_o       = 1'b0;
        src_b_sel_o          = 1'b0;
        regfile_addr_3_sel_o = REGFILE_ADDR_SEL_RD;
        case (state_q)
            FETCH: begin
                if (halt_i) begin
                    state_d = HALT;
                end else begin
                    ir_write_en_o = !stall_c;
                    if (!stall_c) state_d = EXEC;
                end
            end
            EXEC: begin
                pc_write_en_o  = !stall_c;
                ram_addr_sel_o = is_lw_c || is_sw_c;
                if (is_lw_c) begin
                    regfile_write_en_o   = !stall_c;
                    regfile_addr_3_sel_o = REGFILE_ADDR_SEL_RT;
                    src_b_sel_o          = 1'b1;
                end else if (is_sw_c) begin
                    src_b_sel_o          = 1'b1;
                end else if (is_ialu_c) begin
                    regfile_write_en_o   = 1'b1;
                    regfile_addr_3_sel_o = REGFILE_ADDR_SEL_RT;
                    src_b_sel_o          = 1'b1;
                end else if (is_ralu_c) begin
                    regfile_write_en_o   = 1'b1;
                end
                if (!stall_c) state_d = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    exec_alu u_alu (
        .clk                 (clk),
        .reset               (reset),
        .hilo_en_i           ((state_q == EXEC) && !stall_c),
        .opcode_i            (opcode_i),
        .funct_i             (funct_i),
        .rs_i                (rs_i),
        .rt_i                (rt_i),
        .immediate_i         (immediate_i),
        .ram_readdata_i      (ram_readdata_i),
        .rd_o                (rd_o),
        .rt_o                (rt_o),
        .effective_address_o (effective_address_o),
        .mfhi_o              (mfhi_o),
        .mflo_o              (mflo_o)
    );

endmodule

// File: tb/tb_mips_exec_ctrl.sv
// Self-checking bench for mips_exec_ctrl: a spec-level model checked every cycle,
// plus directed vectors with hand-computed results. Honours MIPS_MULTDIV_EN.
module tb_mips_exec_ctrl;

    localparam logic [5:0] OP_R = 6'h00, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
        OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E,
        OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07,
        FN_JR = 6'h08, FN_MFHI = 6'h10, FN_MTHI = 6'h11, FN_MFLO = 6'h12,
        FN_MTLO = 6'h13, FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV = 6'h1A,
        FN_DIVU = 6'h1B, FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND = 6'h24,
        FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2A, FN_SLTU = 6'h2B;

    logic        clk, reset, halt_i, waitrequest_i;
    logic [5:0]  opcode_i, funct_i;
    logic [31:0] rs_i, rt_i, ram_readdata_i;
    logic [15:0] immediate_i;
    logic [1:0]  state_o;
    logic        active_o, pc_write_en_o, ir_write_en_o, regfile_write_en_o;
    logic        ram_read_en_o, ram_write_en_o, ram_addr_sel_o, src_b_sel_o;
    logic        regfile_addr_3_sel_o;
    logic [3:0]  ram_byte_en_o;
    logic [31:0] rd_o, rt_o, effective_address_o, mfhi_o, mflo_o;

    int checks = 0;
    int errors = 0;

    mips_exec_ctrl dut (
        .clk(clk), .reset(reset), .halt_i(halt_i), .waitrequest_i(waitrequest_i),
        .opcode_i(opcode_i), .funct_i(funct_i), .rs_i(rs_i), .rt_i(rt_i),
        .immediate_i(immediate_i), .ram_readdata_i(ram_readdata_i),
        .state_o(state_o), .active_o(active_o), .pc_write_en_o(pc_write_en_o),
        .ir_write_en_o(ir_write_en_o), .regfile_write_en_o(regfile_write_en_o),
        .ram_read_en_o(ram_read_en_o), .ram_write_en_o(ram_write_en_o),
        .ram_addr_sel_o(ram_addr_sel_o), .ram_byte_en_o(ram_byte_en_o),
        .src_b_sel_o(src_b_sel_o), .regfile_addr_3_sel_o(regfile_addr_3_sel_o),
        .rd_o(rd_o), .rt_o(rt_o), .effective_address_o(effective_address_o),
        .mfhi_o(mfhi_o), .mflo_o(mflo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- spec-level model ----------------
    int          m_ph;            // 0 fetch, 1 exec, 2 halt
    logic [31:0] m_hi, m_lo;

    function automatic bit i_alu(input logic [5:0] op);
        return op inside {OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI};
    endfunction

    function automatic bit r_wr(input logic [5:0] op, input logic [5:0] fn);
        return (op == OP_R) && (fn inside {FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR,
            FN_NOR, FN_SLT, FN_SLTU, FN_SLLV, FN_SRLV, FN_SRAV, FN_MFHI, FN_MFLO});
    endfunction

    function automatic logic [31:0] r_res(input logic [5:0] fn, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        int sb;
        sb = int'(b);
        case (fn)
            FN_ADDU: return a + b;
            FN_SUBU: return a - b;
            FN_AND:  return a & b;
            FN_OR:   return a | b;
            FN_XOR:  return a ^ b;
            FN_NOR:  return ~(a | b);
            FN_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            FN_SLTU: return (a < b) ? 32'd1 : 32'd0;
            FN_SLLV: return b << a[4:0];
            FN_SRLV: return b >> a[4:0];
            FN_SRAV: return 32'(sb >>> a[4:0]);
            FN_MFHI: return hi;
            FN_MFLO: return lo;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] i_res(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [15:0] imm,
                                          input logic [31:0] rdata);
        logic [31:0] se, ze;
        se = {{16{imm[15]}}, imm};
        ze = {16'h0, imm};
        case (op)
            OP_ADDIU: return a + se;
            OP_SLTI:  return (int'(a) < int'(se)) ? 32'd1 : 32'd0;
            OP_SLTIU: return (a < se) ? 32'd1 : 32'd0;
            OP_ANDI:  return a & ze;
            OP_ORI:   return a | ze;
            OP_XORI:  return a ^ ze;
            OP_LUI:   return {imm, 16'h0};
            OP_LW:    return rdata;
            OP_SW:    return b;
            default:  return 32'd0;
        endcase
    endfunction

    // Model state advance
    always @(posedge clk) begin
        bit bus, stl;
        logic [63:0] p;
        bus = (m_ph == 0 && !halt_i) || (m_ph == 1 && (opcode_i == OP_LW || opcode_i == OP_SW));
        stl = bus && waitrequest_i;
        p = '0;
        if (reset) begin
            m_ph <= 0; m_hi <= '0; m_lo <= '0;
        end else if (m_ph == 0) begin
            if (halt_i) m_ph <= 2;
            else if (!stl) m_ph <= 1;
        end else if (m_ph == 1 && !stl) begin
            m_ph <= 0;
`ifdef MIPS_MULTDIV_EN
            if (opcode_i == OP_R) begin
                case (funct_i)
                    FN_MULT:  begin p = 64'(longint'(int'(rs_i)) * longint'(int'(rt_i))); m_hi <= p[63:32]; m_lo <= p[31:0]; end
                    FN_MULTU: begin p = {32'h0, rs_i} * {32'h0, rt_i}; m_hi <= p[63:32]; m_lo <= p[31:0]; end
                    FN_DIV:   if (rt_i != 0) begin m_lo <= 32'(int'(rs_i) / int'(rt_i)); m_hi <= 32'(int'(rs_i) % int'(rt_i)); end
                    FN_DIVU:  if (rt_i != 0) begin m_lo <= rs_i / rt_i; m_hi <= rs_i % rt_i; end
                    FN_MTHI:  m_hi <= rs_i;
                    FN_MTLO:  m_lo <= rs_i;
                    default: ;
                endcase
            end
`endif
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        bit ft, ex, lw, sw, rde, wre, stl, rfw;
        if (!reset) begin
            ft  = (m_ph == 0);
            ex  = (m_ph == 1);
            lw  = (opcode_i == OP_LW);
            sw  = (opcode_i == OP_SW);
            rde = (ft && !halt_i) || (ex && lw);
            wre = ex && sw;
            stl = (rde || wre) && waitrequest_i;
            rfw = ex && (lw ? !stl : (i_alu(opcode_i) || r_wr(opcode_i, funct_i)));
            chk("state", 32'(state_o), 32'(m_ph));
            chk("active", 32'(active_o), 32'(m_ph != 2));
            chk("ram_read_en", 32'(ram_read_en_o), 32'(rde));
            chk("ram_write_en", 32'(ram_write_en_o), 32'(wre));
            chk("byte_en", 32'(ram_byte_en_o), (rde || wre) ? 32'hF : 32'h0);
            chk("ir_write_en", 32'(ir_write_en_o), 32'(ft && !halt_i && !stl));
            chk("pc_write_en", 32'(pc_write_en_o), 32'(ex && !stl));
            chk("regfile_write_en", 32'(regfile_write_en_o), 32'(rfw));
            chk("mfhi", mfhi_o, m_hi);
            chk("mflo", mflo_o, m_lo);
            if (rde || wre) chk("addr_sel", 32'(ram_addr_sel_o), 32'(ex));
            if (ex && (lw || i_alu(opcode_i))) begin
                chk("addr3_sel_rt", 32'(regfile_addr_3_sel_o), 32'd1);
                chk("src_b_sel_imm", 32'(src_b_sel_o), 32'd1);
            end
            if (ex && r_wr(opcode_i, funct_i)) begin
                chk("addr3_sel_rd", 32'(regfile_addr_3_sel_o), 32'd0);
                chk("src_b_sel_reg", 32'(src_b_sel_o), 32'd0);
                chk("rd_o", rd_o, r_res(funct_i, rs_i, rt_i, m_hi, m_lo));
            end
            if (ex && (lw || sw || i_alu(opcode_i)))
                chk("rt_o", rt_o, i_res(opcode_i, rs_i, rt_i, immediate_i, ram_readdata_i));
            if (ex && (lw || sw))
                chk("eff_addr", effective_address_o, rs_i + {{16{immediate_i[15]}}, immediate_i});
        end
    end

    // ---------------- directed stimulus ----------------
    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] imm;
        int          dst;   // 0 rd, 1 rt, 2 no register write
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Lands at posedge+3, clear of both clock edges
    task automatic settle();
        #2;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                             input logic [31:0] b, input logic [15:0] imm, input logic [31:0] rdata);
        opcode_i = op; funct_i = fn; rs_i = a; rt_i = b; immediate_i = imm; ram_readdata_i = rdata;
    endtask

    task automatic run_phase(input int nwait);
        for (int i = 0; i < nwait; i++) begin
            waitrequest_i = 1'b1;
            step();
        end
        waitrequest_i = 1'b0;
        step();
    endtask

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [15:0] imm, input int dst,
                       input logic [31:0] exp);
        vec_t v;
        v.op = op; v.fn = fn; v.a = a; v.b = b; v.imm = imm; v.dst = dst; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b1; halt_i = 1'b0; waitrequest_i = 1'b0;
        set_instr(6'h0, 6'h0, 32'h0, 32'h0, 16'h0, 32'h0);
        repeat (3) step();
        reset = 1'b0;
        settle();
        chk("reset_state", 32'(state_o), 32'd0);
        chk("reset_active", 32'(active_o), 32'd1);
        chk("reset_hi", mfhi_o, 32'h0);
        chk("reset_lo", mflo_o, 32'h0);

        // Fetch held by waitrequest for three cycles, then ADDIU
        set_instr(OP_ADDIU, 6'h0, 32'h0000_0005, 32'h0, 16'hFFFF, 32'h0);
        waitrequest_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("fetch_wait_state", 32'(state_o), 32'd0);
            chk("fetch_wait_ir_we", 32'(ir_write_en_o), 32'd0);
            step();
        end
        waitrequest_i = 1'b0;
        settle();
        chk("fetch_go_ir_we", 32'(ir_write_en_o), 32'd1);
        step();
        settle();
        chk("fetch_to_exec", 32'(state_o), 32'd1);
        chk("addiu_rt", rt_o, 32'h0000_0004);
        chk("addiu_addr3_sel", 32'(regfile_addr_3_sel_o), 32'd1);
        chk("addiu_rf_we", 32'(regfile_write_en_o), 32'd1);
        run_phase(0);

        // LW with a stalled bus access
        set_instr(OP_LW, 6'h0, 32'h0000_1000, 32'h0, 16'h0004, 32'hDEAD_BEEF);
        run_phase(0);
        waitrequest_i = 1'b1;
        settle();
        chk("lw_addr_sel", 32'(ram_addr_sel_o), 32'd1);
        chk("lw_ea", effective_address_o, 32'h0000_1004);
        chk("lw_rt", rt_o, 32'hDEAD_BEEF);
        chk("lw_stall_rf_we", 32'(regfile_write_en_o), 32'd0);
        chk("lw_stall_pc_we", 32'(pc_write_en_o), 32'd0);
        step();
        waitrequest_i = 1'b0;
        settle();
        chk("lw_held_exec", 32'(state_o), 32'd1);
        chk("lw_rf_we", 32'(regfile_write_en_o), 32'd1);
        step();

        // SW
        set_instr(OP_SW, 6'h0, 32'h0000_2000, 32'hCAFE_F00D, 16'hFFF8, 32'h0);
        run_phase(1);
        settle();
        chk("sw_write", 32'(ram_write_en_o), 32'd1);
        chk("sw_data", rt_o, 32'hCAFE_F00D);
        chk("sw_ea", effective_address_o, 32'h0000_1FF8);
        chk("sw_byte_en", 32'(ram_byte_en_o), 32'hF);
        step();

        // ALU vectors with hand-computed results
        add(OP_R, FN_SLT,  32'h8000_0000, 32'h1, 16'h0, 0, 32'h1);
        add(OP_R, FN_SLTU, 32'h8000_0000, 32'h1, 16'h0, 0, 32'h0);
        add(OP_R, FN_SUBU, 32'h5, 32'h7, 16'h0, 0, 32'hFFFF_FFFE);
        add(OP_R, FN_NOR,  32'hF0F0_0000, 32'h0000_0F0F, 16'h0, 0, 32'h0F0F_F0F0);
        add(OP_R, FN_SRAV, 32'h4, 32'h8000_0000, 16'h0, 0, 32'hF800_0000);
        add(OP_R, FN_SLLV, 32'h24, 32'h1, 16'h0, 0, 32'h10);
        add(OP_R, FN_SRLV, 32'd31, 32'h8000_0000, 16'h0, 0, 32'h1);
        add(OP_R, FN_ADDU, 32'hFFFF_FFFF, 32'h2, 16'h0, 0, 32'h1);
        add(OP_R, FN_AND,  32'hFF00_FF00, 32'h0F0F_0F0F, 16'h0, 0, 32'h0F00_0F00);
        add(OP_R, FN_OR,   32'hFF00_FF00, 32'h0F0F_0F0F, 16'h0, 0, 32'hFF0F_FF0F);
        add(OP_R, FN_XOR,  32'hFF00_FF00, 32'h0F0F_0F0F, 16'h0, 0, 32'hF00F_F00F);
        add(OP_R, FN_MFHI, 32'h0, 32'h0, 16'h0, 0, 32'h0);
        add(OP_SLTI,  6'h0, 32'hFFFF_FFFF, 32'h0, 16'h0000, 1, 32'h1);
        add(OP_SLTIU, 6'h0, 32'h5, 32'h0, 16'hFFFF, 1, 32'h1);
        add(OP_ANDI,  6'h0, 32'hFFFF_1234, 32'h0, 16'hF0F0, 1, 32'h0000_1030);
        add(OP_ORI,   6'h0, 32'h1234_0000, 32'h0, 16'h8001, 1, 32'h1234_8001);
        add(OP_XORI,  6'h0, 32'h0000_FFFF, 32'h0, 16'hFFFF, 1, 32'h0);
        add(OP_LUI,   6'h0, 32'h0, 32'h0, 16'hABCD, 1, 32'hABCD_0000);
        add(OP_R, FN_JR, 32'h100, 32'h0, 16'h0, 2, 32'h0);
        add(6'h3F, 6'h0, 32'h1, 32'h2, 16'h3, 2, 32'h0);
        add(OP_R, 6'h3F, 32'h1, 32'h2, 16'h3, 2, 32'h0);
        foreach (vecs[i]) begin
            set_instr(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].imm, 32'h0);
            run_phase(i % 2);
            settle();
            if (vecs[i].dst == 0) chk($sformatf("vec%0d_rd", i), rd_o, vecs[i].exp);
            else if (vecs[i].dst == 1) chk($sformatf("vec%0d_rt", i), rt_o, vecs[i].exp);
            else begin
                chk($sformatf("vec%0d_no_rf_we", i), 32'(regfile_write_en_o), 32'd0);
                chk($sformatf("vec%0d_pc_we", i), 32'(pc_write_en_o), 32'd1);
            end
            step();
        end

        // HI/LO instructions
        set_instr(OP_R, FN_MULT, 32'hFFFF_FFFE, 32'h3, 16'h0, 32'h0);
        run_phase(0); run_phase(0); settle();
`ifdef MIPS_MULTDIV_EN
        chk("mult_hi", mfhi_o, 32'hFFFF_FFFF);
        chk("mult_lo", mflo_o, 32'hFFFF_FFFA);
`else
        chk("mult_nop_hi", mfhi_o, 32'h0);
        chk("mult_nop_lo", mflo_o, 32'h0);
`endif
        set_instr(OP_R, FN_DIVU, 32'h7, 32'h0, 16'h0, 32'h0);
        run_phase(0); run_phase(0); settle();
`ifdef MIPS_MULTDIV_EN
        chk("divu0_hi", mfhi_o, 32'hFFFF_FFFF);
        chk("divu0_lo", mflo_o, 32'hFFFF_FFFA);
`else
        chk("divu0_hi", mfhi_o, 32'h0);
`endif
        set_instr(OP_R, FN_DIV, 32'hFFFF_FFF9, 32'h2, 16'h0, 32'h0);
        run_phase(0); run_phase(0);
        set_instr(OP_R, FN_MFLO, 32'h0, 32'h0, 16'h0, 32'h0);
        run_phase(0); settle();
`ifdef MIPS_MULTDIV_EN
        chk("div_mflo", rd_o, 32'hFFFF_FFFD);
        chk("div_hi", mfhi_o, 32'hFFFF_FFFF);
`else
        chk("div_nop_mflo", rd_o, 32'h0);
`endif
        step();
        set_instr(OP_R, FN_MTHI, 32'h1234_5678, 32'h0, 16'h0, 32'h0);
        run_phase(0); run_phase(0); settle();
`ifdef MIPS_MULTDIV_EN
        chk("mthi", mfhi_o, 32'h1234_5678);
`else
        chk("mthi_nop", mfhi_o, 32'h0);
`endif

        // Reset in the middle of a stalled LW
        set_instr(OP_LW, 6'h0, 32'h40, 32'h0, 16'h0, 32'h1111_2222);
        run_phase(0);
        waitrequest_i = 1'b1;
        step();
        settle();
        chk("stall_hold_exec", 32'(state_o), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        waitrequest_i = 1'b0;
        settle();
        chk("midstall_reset_state", 32'(state_o), 32'd0);
        chk("midstall_reset_hi", mfhi_o, 32'h0);
        chk("midstall_reset_lo", mflo_o, 32'h0);

        // Halt is sticky until reset
        halt_i = 1'b1;
        settle();
        chk("halt_fetch_no_read", 32'(ram_read_en_o), 32'd0);
        step();
        halt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("halt_state", 32'(state_o), 32'd2);
            chk("halt_active", 32'(active_o), 32'd0);
            chk("halt_read", 32'(ram_read_en_o), 32'd0);
            chk("halt_write", 32'(ram_write_en_o), 32'd0);
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        settle();
        chk("halt_exit_state", 32'(state_o), 32'd0);
        chk("halt_exit_active", 32'(active_o), 32'd1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
